mreq_arb2: RTL and testbench

- Two-requester arbiter for the MREQ execution bus of the Wishbone control path.
- Shares one downstream execution channel (MREQ sequencer plus its Rx/Tx byte streams) between two command sources, e.g. the host command parser and an internal command generator.
- Grants one requester at a time with round-robin fairness.
- Holds the grant for the full MREQ transaction and routes that requester's byte streams to the executor for the whole grant.

---
 rtl/mreq_arb2.sv | 174 +++++++++++++++++
 tb/tb_mreq_arb2.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mreq_arb2.sv
// ---------------------------------------------------------------------------
// mreq_arb2 : two-requester round-robin arbiter for the MREQ execution bus.
//
// Shares one MREQ executor (sequencer + Rx/Tx byte streams) between two
// command sources. One requester is granted at a time. The grant is held
// for the whole MREQ transaction, and that requester's byte streams are
// routed to the executor until the executor signals completion.
//
// Parameters
//   MREQ_W      packed MREQ width {wr, wsize[1:0], aincr, size[7:0], addr[31:0]}
//   WDT_CYCLES  grant-duration limit for the optional watchdog (1..65535)
//
// Optional feature (macro MREQ_ARB2_WDT_EN)
//   A 16-bit saturating counter measures grant duration. o_err_timeout is a
//   sticky flag that is cleared only by reset. The flag never aborts a grant.
//   Without the macro there is no counter and o_err_timeout is tied to 0.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_m_mreq_valid[1:0]       per-requester MREQ valid
//   o_m_mreq_ready[1:0]       per-requester completion pulse
//   i_m_mreq[2*MREQ_W-1:0]    requester k MREQ at [k*MREQ_W +: MREQ_W]
//   i_m_rx_data[15:0]         requester k write byte at [k*8 +: 8]
//   i_m_rx_valid/o_m_rx_ready per-requester write-byte handshake
//   o_m_tx_data[7:0]          read byte, broadcast to both requesters
//   o_m_tx_valid/i_m_tx_ready per-requester read-byte handshake
//   o_s_mreq_valid/i_s_mreq_ready/o_s_mreq   MREQ to executor
//   o_s_rx_data/o_s_rx_valid/i_s_rx_ready    write bytes to executor
//   i_s_tx_data/i_s_tx_valid/o_s_tx_ready    read bytes from executor
//   o_grant[1:0]              registered one-hot grant, 0 when idle
//   o_err_timeout             sticky watchdog flag
// ---------------------------------------------------------------------------
module mreq_arb2 #(
  parameter int MREQ_W     = 44,
  parameter int WDT_CYCLES = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_m_mreq_valid,
  output logic [1:0]            o_m_mreq_ready,
  input  logic [2*MREQ_W-1:0]   i_m_mreq,
  input  logic [15:0]           i_m_rx_data,
  input  logic [1:0]            i_m_rx_valid,
  output logic [1:0]            o_m_rx_ready,
  output logic [7:0]            o_m_tx_data,
  output logic [1:0]            o_m_tx_valid,
  input  logic [1:0]            i_m_tx_ready,
  output logic                  o_s_mreq_valid,
  input  logic                  i_s_mreq_ready,
  output logic [MREQ_W-1:0]     o_s_mreq,
  output logic [7:0]            o_s_rx_data,
  output logic                  o_s_rx_valid,
  input  logic                  i_s_rx_ready,
  input  logic [7:0]            i_s_tx_data,
  input  logic                  i_s_tx_valid,
  output logic                  o_s_tx_ready,
  output logic [1:0]            o_grant,
  output logic                  o_err_timeout
);

  if (WDT_CYCLES < 1 || WDT_CYCLES > 65535) begin : g_wdt_range
    $error("mreq_arb2: WDT_CYCLES must be within 1..65535");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] grant, grant_nxt;
  logic       rr, rr_nxt;     // index of the requester preferred on a tie
  logic       gidx;           // index of the granted requester

  // grant is one-hot while in GRANT, so bit 1 is the requester index
  assign gidx    = grant[1];
  assign o_grant = grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      grant <= 2'b00;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      rr    <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    rr_nxt         = rr;
    o_m_mreq_ready = 2'b00;
    o_m_rx_ready   = 2'b00;
    o_m_tx_data    = 8'h00;
    o_m_tx_valid   = 2'b00;
    o_s_mreq_valid = 1'b0;
    o_s_mreq       = '0;
    o_s_rx_data    = 8'h00;
    o_s_rx_valid   = 1'b0;
    o_s_tx_ready   = 1'b0;

    case (state)
      IDLE: begin
        if (|i_m_mreq_valid) begin
          state_nxt = GRANT;
          if (i_m_mreq_valid == 2'b11)
            grant_nxt = rr ? 2'b10 : 2'b01;
          else
            grant_nxt = i_m_mreq_valid;
        end
      end

      GRANT: begin
        // Everything is routed from the granted requester for the whole
        // transaction; the other requester sees all-zero handshakes.
        o_s_mreq_valid       = i_m_mreq_valid[gidx];
        o_s_mreq             = gidx ? i_m_mreq[2*MREQ_W-1 -: MREQ_W]
                                    : i_m_mreq[MREQ_W-1:0];
        o_m_mreq_ready[gidx] = i_s_mreq_ready;
        o_s_rx_data          = gidx ? i_m_rx_data[15:8] : i_m_rx_data[7:0];
        o_s_rx_valid         = i_m_rx_valid[gidx];
        o_m_rx_ready[gidx]   = i_s_rx_ready;
        o_m_tx_data          = i_s_tx_data;
        o_m_tx_valid[gidx]   = i_s_tx_valid;
        o_s_tx_ready         = i_m_tx_ready[gidx];

        // Release only on executor completion; a dropped request valid
        // does not end the grant. Passing through IDLE gives the bubble.
        if (i_s_mreq_ready) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          rr_nxt    = ~gidx;
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

`ifdef MREQ_ARB2_WDT_EN
  localparam logic [16:0] WDT_LIMIT = 17'(WDT_CYCLES);

  logic [15:0] wdt_cnt;
  logic [16:0] wdt_inc;
  logic        err_q;

  assign wdt_inc       = {1'b0, wdt_cnt} + 17'd1;
  assign o_err_timeout = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdt_cnt <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      // wdt_cnt holds the number of completed GRANT cycles of this grant
      if (state == IDLE && state_nxt == GRANT)
        wdt_cnt <= 16'h0000;
      else if (state == GRANT && wdt_cnt != 16'hFFFF)
        wdt_cnt <= wdt_inc[15:0];
      if (state == GRANT && wdt_inc >= WDT_LIMIT)
        err_q <= 1'b1;
    end
  end
`else
  assign o_err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mreq_arb2.sv
// ---------------------------------------------------------------------------
// tb_mreq_arb2 : self-checking bench for mreq_arb2.
// Table-driven arbitration vectors, hand-written stream/reset/watchdog
// sequences, and a randomized run against a behavioural owner/pointer model.
// ---------------------------------------------------------------------------
module tb_mreq_arb2;

  localparam int MREQ_W = 44;
`ifdef MREQ_ARB2_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [1:0]          mv;
  logic [1:0]          m_mreq_ready;
  logic [2*MREQ_W-1:0] m_mreq;
  logic [15:0]         rx;
  logic [1:0]          rxv;
  logic [1:0]          m_rx_ready;
  logic [7:0]          m_tx_data;
  logic [1:0]          m_tx_valid;
  logic [1:0]          m_tx_ready;
  logic                s_mreq_valid;
  logic                sr;
  logic [MREQ_W-1:0]   s_mreq;
  logic [7:0]          s_rx_data;
  logic                s_rx_valid;
  logic                s_rx_ready;
  logic [7:0]          s_tx_data;
  logic                s_tx_valid;
  logic                s_tx_ready;
  logic [1:0]          grant;
  logic                err;

  int n_chk  = 0;
  int n_fail = 0;
  int owner  = -1;   // model: granted requester, -1 when idle
  int rr     = 0;    // model: requester preferred on a tie

  mreq_arb2 #(.MREQ_W(MREQ_W), .WDT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m_mreq_valid(mv), .o_m_mreq_ready(m_mreq_ready), .i_m_mreq(m_mreq),
    .i_m_rx_data(rx), .i_m_rx_valid(rxv), .o_m_rx_ready(m_rx_ready),
    .o_m_tx_data(m_tx_data), .o_m_tx_valid(m_tx_valid), .i_m_tx_ready(m_tx_ready),
    .o_s_mreq_valid(s_mreq_valid), .i_s_mreq_ready(sr), .o_s_mreq(s_mreq),
    .o_s_rx_data(s_rx_data), .o_s_rx_valid(s_rx_valid), .i_s_rx_ready(s_rx_ready),
    .i_s_tx_data(s_tx_data), .i_s_tx_valid(s_tx_valid), .o_s_tx_ready(s_tx_ready),
    .o_grant(grant), .o_err_timeout(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  localparam logic [43:0] MREQ0 = {1'b1, 2'b00, 1'b0, 8'd4, 32'h0000_0100};
  localparam logic [43:0] MREQ1 = {1'b0, 2'b01, 1'b1, 8'd8, 32'h0000_2000};

  typedef struct {
    logic [1:0]  v;
    logic        sr;
    logic [1:0]  g;
    logic        sv;
    logic [1:0]  mr;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  function automatic logic [70:0] dut_out();
    return {grant, s_mreq_valid, s_mreq, m_mreq_ready, s_rx_data, s_rx_valid,
            m_rx_ready, m_tx_data, m_tx_valid, s_tx_ready};
  endfunction

  // Expected outputs from the arbitration rules: idle means everything is 0,
  // otherwise every stream is taken from the owner requester.
  function automatic logic [70:0] model_out(int own);
    logic [1:0]  gr  = 2'b00;
    logic [1:0]  mr  = 2'b00;
    logic [1:0]  rxr = 2'b00;
    logic [1:0]  txv = 2'b00;
    logic        sv  = 1'b0;
    logic        rv  = 1'b0;
    logic        txr = 1'b0;
    logic [43:0] mq  = '0;
    logic [7:0]  rxd = 8'h00;
    logic [7:0]  txd = 8'h00;
    if (own >= 0) begin
      gr[own]  = 1'b1;
      sv       = mv[own];
      mq       = m_mreq[own*MREQ_W +: MREQ_W];
      mr[own]  = sr;
      rxd      = rx[own*8 +: 8];
      rv       = rxv[own];
      rxr[own] = s_rx_ready;
      txd      = s_tx_data;
      txv[own] = s_tx_valid;
      txr      = m_tx_ready[own];
    end
    return {gr, sv, mq, mr, rxd, rv, rxr, txd, txv, txr};
  endfunction

  task automatic model_step();
    if (owner < 0) begin
      if (mv == 2'b11)      owner = rr;
      else if (mv == 2'b01) owner = 0;
      else if (mv == 2'b10) owner = 1;
    end else if (sr) begin
      rr    = 1 - owner;
      owner = -1;
    end
  endtask

  task automatic clear_inputs();
    mv = 2'b00; sr = 1'b0; rx = 16'h0000; rxv = 2'b00; m_tx_ready = 2'b00;
    s_rx_ready = 1'b0; s_tx_data = 8'h00; s_tx_valid = 1'b0;
    m_mreq = {MREQ1, MREQ0};
  endtask

  // Ends at posedge+1 with reset released and the model idle.
  task automatic do_reset();
    rst_n = 1'b0;
    mv = 2'b11; sr = 1'b1; rxv = 2'b11; rx = 16'hFFFF; s_tx_valid = 1'b1;
    s_tx_data = 8'hFF; m_tx_ready = 2'b11; s_rx_ready = 1'b1;
    #2;
    chk("reset_outputs", 128'(dut_out()), 128'(0));
    chk("reset_err", 128'(err), 128'(0));
    tick();
    clear_inputs();
    rst_n = 1'b1;
    owner = -1;
    rr    = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #1;
    do_reset();

    // ---- table: arbitration, alternation, IDLE bubble, boundary cases
    tbl[0]  = '{2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    tbl[1]  = '{2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 32'h100};
    tbl[2]  = '{2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 32'h100};
    tbl[3]  = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    tbl[4]  = '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 32'h2000};
    tbl[5]  = '{2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 32'h0};
    tbl[6]  = '{2'b11, 1'b0, 2'b01, 1'b1, 2'b00, 32'h100};
    tbl[7]  = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 32'h100};
    tbl[8]  = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    tbl[9]  = '{2'b10, 1'b0, 2'b10, 1'b1, 2'b00, 32'h2000};
    tbl[10] = '{2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 32'h2000};
    tbl[11] = '{2'b01, 1'b0, 2'b10, 1'b0, 2'b00, 32'h2000};
    tbl[12] = '{2'b01, 1'b1, 2'b10, 1'b0, 2'b10, 32'h2000};
    tbl[13] = '{2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    tbl[14] = '{2'b00, 1'b1, 2'b01, 1'b0, 2'b01, 32'h100};
    tbl[15] = '{2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    tbl[16] = '{2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    tbl[17] = '{2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 32'h100};
    tbl[18] = '{2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    for (int i = 0; i < 19; i++) begin
      mv = tbl[i].v;
      sr = tbl[i].sr;
      settle();
      chk($sformatf("tbl%0d_grant", i), 128'(grant), 128'(tbl[i].g));
      chk($sformatf("tbl%0d_s_valid", i), 128'(s_mreq_valid), 128'(tbl[i].sv));
      chk($sformatf("tbl%0d_m_ready", i), 128'(m_mreq_ready), 128'(tbl[i].mr));
      chk($sformatf("tbl%0d_addr", i), 128'(s_mreq[31:0]), 128'(tbl[i].addr));
      if (i == 1) chk("tbl1_wr", 128'(s_mreq[43]), 128'(1));
      tick();
    end
    clear_inputs();

    // ---- write of 3 bytes from requester 1, requester 0 noise on its lane
    mv = 2'b10;
    tick();
    begin
      logic [7:0] bytes [3];
      bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
      for (int i = 0; i < 3; i++) begin
        rx = {bytes[i], 8'h77}; rxv = 2'b11; s_rx_ready = 1'b1;
        settle();
        chk($sformatf("wr_byte%0d", i), 128'(s_rx_data), 128'(bytes[i]));
        chk($sformatf("wr_valid%0d", i), 128'(s_rx_valid), 128'(1));
        chk($sformatf("wr_rx_ready%0d", i), 128'(m_rx_ready), 128'(2'b10));
        tick();
      end
    end
    rxv = 2'b00; s_rx_ready = 1'b0; sr = 1'b1;
    settle();
    chk("wr_done_ready", 128'(m_mreq_ready), 128'(2'b10));
    tick();
    clear_inputs();
    settle();
    chk("wr_release", 128'(grant), 128'(0));
    tick();

    // ---- read to requester 0, tx_ready initially only from requester 1
    mv = 2'b01;
    tick();
    s_tx_valid = 1'b1; s_tx_data = 8'h5A; m_tx_ready = 2'b10;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("rd_tx_ready_wait%0d", i), 128'(s_tx_ready), 128'(0));
      chk($sformatf("rd_tx_valid_wait%0d", i), 128'(m_tx_valid), 128'(2'b01));
      chk($sformatf("rd_tx_data%0d", i), 128'(m_tx_data), 128'(8'h5A));
      tick();
    end
    m_tx_ready = 2'b01;
    settle();
    chk("rd_tx_ready_go", 128'(s_tx_ready), 128'(1));
    chk("rd_tx_valid_go", 128'(m_tx_valid), 128'(2'b01));
    tick();
    s_tx_valid = 1'b0; m_tx_ready = 2'b00; sr = 1'b1;
    tick();
    clear_inputs();
    tick();

    // ---- reset mid-grant after 2 of 4 bytes of a requester 1 write
    mv = 2'b10;
    tick();
    rx = 16'h3300; rxv = 2'b10; s_rx_ready = 1'b1;
    tick();
    rx = 16'h4400;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_grant", 128'(grant), 128'(0));
    chk("rst_mid_s_valid", 128'(s_mreq_valid), 128'(0));
    chk("rst_mid_rx", 128'({s_rx_valid, m_rx_ready}), 128'(0));
    chk("rst_mid_all", 128'(dut_out()), 128'(0));
    tick();
    rst_n = 1'b1;
    clear_inputs();
    mv = 2'b11;
    tick();
    settle();
    chk("rst_after_grant", 128'(grant), 128'(2'b01));
    @(posedge clk); #1;
    sr = 1'b1;
    tick();
    clear_inputs();
    tick();

    // ---- randomized run against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      mv         = 2'($urandom_range(0, 3));
      sr         = ($urandom_range(0, 3) == 0);
      m_mreq     = 88'({$urandom(), $urandom(), $urandom()});
      rx         = 16'($urandom());
      rxv        = 2'($urandom_range(0, 3));
      m_tx_ready = 2'($urandom_range(0, 3));
      s_rx_ready = 1'($urandom_range(0, 1));
      s_tx_data  = 8'($urandom());
      s_tx_valid = 1'($urandom_range(0, 1));
      settle();
      chk($sformatf("rand%0d", c), 128'(dut_out()), 128'(model_out(owner)));
      @(posedge clk);
      model_step();
      #1;
    end
    clear_inputs();

    // ---- watchdog: hold a grant for 10 cycles with limit 8
    do_reset();
    mv = 2'b01;
    tick();
    for (int i = 1; i <= 10; i++) begin
      tick();
      settle();
      chk($sformatf("wdt_cycle%0d", i), 128'(err), 128'(WDT_ON && i >= 8));
      chk($sformatf("wdt_grant%0d", i), 128'(grant), 128'(2'b01));
    end
    @(posedge clk); #1;
    sr = 1'b1;
    tick();
    clear_inputs();
    settle();
    chk("wdt_after_release_grant", 128'(grant), 128'(0));
    chk("wdt_sticky", 128'(err), 128'(WDT_ON));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
